// File: rtl/ex_pkg.sv
// Shared definitions for the EX stage and EX/MEM pipeline register:
// ALUOp classes, R-type funct codes, internal ALU control codes,
// forwarding-select encoding, the control-bundle layout and small
// decode helpers used by ex_mem_stage and alu.
package ex_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 2;

  // ALUOp classes produced by the main decoder
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 2'b11;

  // R-type funct field values
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_NOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  // Control bundle carried from ID/EX into EX/MEM
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic jump;
  } ctrl_t;

  // Map an ALUOp class (and funct for R-type) onto an ALU operation;
  // unknown funct codes fall back to add.
  function automatic alu_ctrl_e alu_decode(input logic [ALUOP_W-1:0] op,
                                           input logic [FUNCT_W-1:0] funct);
    alu_ctrl_e ctrl;
    ctrl = ALU_ADD;
    unique case (op)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_OR:  ctrl = ALU_OR;
      default: begin
        unique case (funct)
          FUNCT_SUB: ctrl = ALU_SUB;
          FUNCT_AND: ctrl = ALU_AND;
          FUNCT_OR:  ctrl = ALU_OR;
          FUNCT_NOR: ctrl = ALU_NOR;
          FUNCT_SLT: ctrl = ALU_SLT;
          default:   ctrl = ALU_ADD;
        endcase
      end
    endcase
    return ctrl;
  endfunction

  // Forwarding priority: older EX/MEM result first, then MEM/WB; r0 never matches.
  function automatic fwd_sel_e fwd_select(input logic             exmem_we,
                                          input logic [REG_W-1:0] exmem_rd,
                                          input logic             memwb_we,
                                          input logic [REG_W-1:0] memwb_rd,
                                          input logic [REG_W-1:0] src);
    fwd_sel_e sel;
    sel = FWD_REG;
    if (exmem_we && (exmem_rd != '0) && (exmem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_mem_stage_alu.sv
// alu: combinational 32-bit ALU with wrap-around arithmetic.
// Ports: a_i, b_i operands; ctrl_i operation select;
//        result_c result; zero_c asserted when result is zero.
module alu
  import ex_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_ctrl_e         ctrl_i,
  output logic [DATA_W-1:0] result_c,
  output logic              zero_c
);

  always_comb begin
    result_c = '0;
    unique case (ctrl_i)
      ALU_ADD: result_c = a_i + b_i;
      ALU_SUB: result_c = a_i - b_i;
      ALU_AND: result_c = a_i & b_i;
      ALU_OR:  result_c = a_i | b_i;
      ALU_NOR: result_c = ~(a_i | b_i);
      ALU_SLT: result_c = ($signed(a_i) < $signed(b_i)) ? DATA_W'(1) : '0;
      default: result_c = a_i + b_i;
    endcase
  end

  assign zero_c = (result_c == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage plus EX/MEM pipeline register.
// Inputs: ID/EX control, operands, register numbers and funct; MEM/WB
//         forwarding source; EX_Flush squashes the control of the
//         instruction being captured; clk, rst (async, active-high).
// Outputs: registered control, branch/jump targets, ALU result, zero
//          flag, forwarded store data and destination register.
module ex_mem_stage
  import ex_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWrite_in,
  input  logic               MemtoReg_in,
  input  logic               Branch_in,
  input  logic               MemRead_in,
  input  logic               MemWrite_in,
  input  logic               Jump_in,
  input  logic               RegDst_in,
  input  logic               ALUSrc_in,
  input  logic [ALUOP_W-1:0] ALUOp_in,
  input  logic [DATA_W-1:0]  jump_addr_in,
  input  logic [DATA_W-1:0]  PC_plus4_in,
  input  logic [DATA_W-1:0]  reg_read_data_1_in,
  input  logic [DATA_W-1:0]  reg_read_data_2_in,
  input  logic [DATA_W-1:0]  immi_sign_extended_in,
  input  logic [REG_W-1:0]   IF_ID_RegisterRs_in,
  input  logic [REG_W-1:0]   IF_ID_RegisterRt_in,
  input  logic [REG_W-1:0]   IF_ID_RegisterRd_in,
  input  logic [FUNCT_W-1:0] IF_ID_funct_in,
  input  logic               MEM_WB_RegWrite,
  input  logic [REG_W-1:0]   MEM_WB_RegisterRd,
  input  logic [DATA_W-1:0]  MEM_WB_write_data,
  input  logic               EX_Flush,
  output logic               RegWrite_out,
  output logic               MemtoReg_out,
  output logic               Branch_out,
  output logic               MemRead_out,
  output logic               MemWrite_out,
  output logic               Jump_out,
  output logic [DATA_W-1:0]  branch_addr_out,
  output logic [DATA_W-1:0]  jump_addr_out,
  output logic [DATA_W-1:0]  ALU_result_out,
  output logic [DATA_W-1:0]  write_data_out,
  output logic               zero_out,
  output logic [REG_W-1:0]   write_reg_out
);

  ctrl_t              ctrl_in;
  ctrl_t              ctrl_d, ctrl_q;
  logic [DATA_W-1:0]  branch_d, branch_q;
  logic [DATA_W-1:0]  jump_d, jump_q;
  logic [DATA_W-1:0]  alu_res_d, alu_res_q;
  logic [DATA_W-1:0]  wdata_d, wdata_q;
  logic               zero_d, zero_q;
  logic [REG_W-1:0]   wreg_d, wreg_q;

  fwd_sel_e           fwd_a_sel, fwd_b_sel;
  logic [DATA_W-1:0]  fwd_a, fwd_b, alu_b;
  alu_ctrl_e          alu_ctrl;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_zero;

  assign ctrl_in = {RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Jump_in};

  // Forwarding selects compare against the registered (older) EX/MEM contents
  assign fwd_a_sel = fwd_select(ctrl_q.reg_write, wreg_q, MEM_WB_RegWrite,
                                MEM_WB_RegisterRd, IF_ID_RegisterRs_in);
  assign fwd_b_sel = fwd_select(ctrl_q.reg_write, wreg_q, MEM_WB_RegWrite,
                                MEM_WB_RegisterRd, IF_ID_RegisterRt_in);

  // Operand muxes
  always_comb begin
    fwd_a = reg_read_data_1_in;
    fwd_b = reg_read_data_2_in;
    unique case (fwd_a_sel)
      FWD_EXMEM: fwd_a = alu_res_q;
      FWD_MEMWB: fwd_a = MEM_WB_write_data;
      default:   fwd_a = reg_read_data_1_in;
    endcase
    unique case (fwd_b_sel)
      FWD_EXMEM: fwd_b = alu_res_q;
      FWD_MEMWB: fwd_b = MEM_WB_write_data;
      default:   fwd_b = reg_read_data_2_in;
    endcase
  end

  assign alu_b    = ALUSrc_in ? immi_sign_extended_in : fwd_b;
  assign alu_ctrl = alu_decode(ALUOp_in, IF_ID_funct_in);

  alu u_alu (
    .a_i      (fwd_a),
    .b_i      (alu_b),
    .ctrl_i   (alu_ctrl),
    .result_c (alu_res),
    .zero_c   (alu_zero)
  );

  // Next-state for the EX/MEM register; flush only clears control
  always_comb begin
    ctrl_d    = EX_Flush ? '0 : ctrl_in;
    branch_d  = PC_plus4_in + {immi_sign_extended_in[DATA_W-3:0], 2'b00};
    jump_d    = jump_addr_in;
    alu_res_d = alu_res;
    wdata_d   = fwd_b;
    zero_d    = alu_zero;
    wreg_d    = RegDst_in ? IF_ID_RegisterRd_in : IF_ID_RegisterRt_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      branch_q  <= '0;
      jump_q    <= '0;
      alu_res_q <= '0;
      wdata_q   <= '0;
      zero_q    <= 1'b0;
      wreg_q    <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      branch_q  <= branch_d;
      jump_q    <= jump_d;
      alu_res_q <= alu_res_d;
      wdata_q   <= wdata_d;
      zero_q    <= zero_d;
      wreg_q    <= wreg_d;
    end
  end

  assign RegWrite_out    = ctrl_q.reg_write;
  assign MemtoReg_out    = ctrl_q.mem_to_reg;
  assign Branch_out      = ctrl_q.branch;
  assign MemRead_out     = ctrl_q.mem_read;
  assign MemWrite_out    = ctrl_q.mem_write;
  assign Jump_out        = ctrl_q.jump;
  assign branch_addr_out = branch_q;
  assign jump_addr_out   = jump_q;
  assign ALU_result_out  = alu_res_q;
  assign write_data_out  = wdata_q;
  assign zero_out        = zero_q;
  assign write_reg_out   = wreg_q;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; asynchronous, active-high.
REQ-003 RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Jump_in  input  1 each  control from ID/EX, forwarded to EX/MEM.
REQ-004 RegDst_in, ALUSrc_in  input  1 each  destination select (1=Rd, 0=Rt); ALU B select (1=immediate, 0=register).
REQ-005 ALUOp_in  input  2  ALU class: 00 add, 01 sub, 10 R-type by funct, 11 or.
REQ-006 jump_addr_in, PC_plus4_in  input  32 each  jump target and PC+4 from ID/EX.
REQ-007 reg_read_data_1_in, reg_read_data_2_in, immi_sign_extended_in  input  32 each  operands from ID/EX.
REQ-008 IF_ID_RegisterRs_in, IF_ID_RegisterRt_in, IF_ID_RegisterRd_in  input  5 each  register numbers.
REQ-009 IF_ID_funct_in  input  6  funct field.
REQ-010 MEM_WB_RegWrite, MEM_WB_RegisterRd, MEM_WB_write_data  input  1/5/32  writeback-stage forwarding source.
REQ-011 EX_Flush  input  1  squash the instruction entering EX/MEM.
REQ-012 RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, Jump_out  output  1 each  registered control.
REQ-013 branch_addr_out, jump_addr_out, ALU_result_out, write_data_out  output  32 each  registered PC+4+(imm<<2), jump target, ALU result, forwarded store data.
REQ-014 zero_out  output  1  registered (ALU result == 0).
REQ-015 write_reg_out  output  5  registered destination register.

Function
REQ-016 Block SHALL have exactly one cycle of latency: inputs present before rising edge N appear on outputs after edge N.
REQ-017 Forward A SHALL select, by priority: EX/MEM (RegWrite_out=1, write_reg_out!=0, write_reg_out==Rs) -> ALU_result_out; else MEM/WB (MEM_WB_RegWrite=1, MEM_WB_RegisterRd!=0, ==Rs) -> MEM_WB_write_data; else reg_read_data_1_in.
REQ-018 Forward B SHALL apply identical rules against Rt; result drives write_data_out and, when ALUSrc_in=0, ALU operand B.
REQ-019 Register 0 SHALL never be a forwarding match.
REQ-020 ALUOp=10 funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt (signed); any other funct SHALL produce add.
REQ-021 Arithmetic SHALL be 32-bit two's-complement wrap-around; no overflow flag or trap.
REQ-022 slt SHALL yield 32'h1 when A<B signed, else 32'h0.
REQ-023 branch_addr SHALL equal PC_plus4_in + (immi_sign_extended_in << 2), truncated to 32 bits.
REQ-024 write_reg SHALL be IF_ID_RegisterRd_in when RegDst_in=1, else IF_ID_RegisterRt_in.
REQ-025 EX_Flush=1 at an edge SHALL load all six control outputs as 0; data outputs still load normally.
REQ-026 Forwarding SHALL use EX/MEM register contents before the edge (the older instruction), never the value being computed.

Reset
REQ-027 rst=1 SHALL immediately, independent of clk, clear every output to 0.
REQ-028 rst asserted mid-operation SHALL discard the in-flight instruction; first edge after deassertion loads the current inputs normally.
REQ-029 While rst=1 forwarding from EX/MEM SHALL be inactive (RegWrite_out=0).

Structure
REQ-030 Shared package ex_pkg SHALL hold ALUOp encodings, funct constants, internal ALU-control codes and forwarding-select encoding (00 register, 01 MEM/WB, 10 EX/MEM).
REQ-031 ALU SHALL be a separate sub-module named alu (combinational: operands, control, result, zero); forwarding, ALU control and EX/MEM register stay in ex_mem_stage.

Verification
REQ-032 Reset: assert rst between edges -> all outputs 0 before next edge; after release, add of 5+7 (ALUOp=00, ALUSrc=0) -> ALU_result_out=12, zero_out=0.
REQ-033 EX/MEM forward: instr1 writes R3=32'h10; instr2 sub Rs=3, Rt=0 reg data 0 -> ALU_result_out=32'h10; same with MEM_WB also matching R3=32'h99 -> EX/MEM value 32'h10 wins.
REQ-034 R0 guard: EX/MEM RegWrite=1 with write_reg=0, ALU_result=32'hFFFF -> Rs=0 operand reads reg_read_data_1_in.
REQ-035 ALU edge cases: 32'h7FFFFFFF+1 -> 32'h80000000; slt -1,1 -> 1; nor 0,0 -> 32'hFFFFFFFF; funct 6'b000000 with ALUOp=10 -> add; sub 4-4 -> zero_out=1.
REQ-036 Flush and branch: PC_plus4=32'h100, imm=32'hFFFFFFFF, Branch_in=1, EX_Flush=1 -> branch_addr_out=32'hFC, all control outputs 0.
REQ-037 Random: 2000 randomized cycles vs reference model, zero mismatches.
